// File: rtl/boreal_dma_pkg.sv
// Shared types for the boreal multi-channel descriptor-ring DMA.
//  - DMA_* localparams: default geometry, also the field widths of dma_desc_t
//  - dma_state_e: engine FSM state encoding, also used by property checkers
//  - dma_desc_t: one ring entry {src, dst, len}
package boreal_dma_pkg;

  localparam int DMA_NUM_CH     = 4;
  localparam int DMA_RING_DEPTH = 16;
  localparam int DMA_ADDR_W     = 10;
  localparam int DMA_DATA_W     = 32;
  localparam int DMA_LEN_W      = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    FETCH  = 3'd2,
    READ   = 3'd3,
    WAIT_R = 3'd4,
    WRITE  = 3'd5,
    WAIT_W = 3'd6,
    NEXT   = 3'd7
  } dma_state_e;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] src;
    logic [DMA_ADDR_W-1:0] dst;
    logic [DMA_LEN_W-1:0]  len;
  } dma_desc_t;

endpackage

// File: rtl/boreal_dma_rr_arb.sv
// Round-robin arbiter: picks the lowest requesting index strictly after
// the last grant, wrapping. Purely combinational.
//  req     in   NUM_CH  request vector
//  last    in   CH_LOG  index of the previous grant
//  gnt     out  NUM_CH  one-hot grant (0 when no request)
//  gnt_idx out  CH_LOG  binary index of the grant
//  valid   out  1       at least one request present
module boreal_dma_rr_arb #(
  parameter int  NUM_CH = 4,
  localparam int CH_LOG = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_LOG-1:0] last,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_LOG-1:0] gnt_idx,
  output logic              valid
);

  logic [CH_LOG-1:0] idx;

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    idx     = '0;
    // NUM_CH is a power of two, so CH_LOG-bit addition wraps the search;
    // off == NUM_CH revisits the last grant itself as the final candidate.
    for (int off = 1; off <= NUM_CH; off++) begin
      idx = last + CH_LOG'(off);
      if (!valid && req[idx]) begin
        valid    = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/boreal_dma_mc_ring.sv
// Multi-channel descriptor-ring DMA engine. Host pushes {src,dst,len}
// descriptors into per-channel rings; channels are served round-robin and
// each descriptor is copied word by word (read then write) over one port.
//  clk, rst                     clock, asynchronous active-high reset
//  desc_push/ch/src/dst/len     descriptor push into ring desc_ch
//  desc_ready                   ring[desc_ch] not full (combinational)
//  ch_enable                    per-channel arbitration enable
//  mem_sel/wr/addr/wdata        memory request (held until mem_ack)
//  mem_rdata, mem_ack           memory response
//  busy, active_ch              engine state / channel being served
//  done                         1-cycle pulse per completed descriptor
//  ch_empty                     per-channel ring empty
module boreal_dma_mc_ring
  import boreal_dma_pkg::*;
#(
  parameter int  NUM_CH     = DMA_NUM_CH,
  parameter int  RING_DEPTH = DMA_RING_DEPTH,
  parameter int  ADDR_W     = DMA_ADDR_W,
  parameter int  DATA_W     = DMA_DATA_W,
  parameter int  LEN_W      = DMA_LEN_W,
  localparam int CH_LOG     = $clog2(NUM_CH),
  localparam int RD_LOG     = $clog2(RING_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              desc_push,
  input  logic [CH_LOG-1:0] desc_ch,
  input  logic [ADDR_W-1:0] desc_src,
  input  logic [ADDR_W-1:0] desc_dst,
  input  logic [LEN_W-1:0]  desc_len,
  output logic              desc_ready,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic              mem_sel,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic [CH_LOG-1:0] active_ch,
  output logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] ch_empty
);

  dma_state_e        state_q, state_d;
  logic [CH_LOG-1:0] gnt_q, gnt_d;
  logic [NUM_CH-1:0] gnt_oh_q, gnt_oh_d;
  dma_desc_t         desc_q, desc_d;
  logic [LEN_W-1:0]  i_q, i_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [RD_LOG-1:0] head_q  [NUM_CH];
  logic [RD_LOG-1:0] head_d  [NUM_CH];
  logic [RD_LOG-1:0] tail_q  [NUM_CH];
  logic [RD_LOG-1:0] tail_d  [NUM_CH];
  logic [RD_LOG:0]   count_q [NUM_CH];
  logic [RD_LOG:0]   count_d [NUM_CH];
  dma_desc_t         ring_q  [NUM_CH][RING_DEPTH];

  logic [NUM_CH-1:0] ch_full;
  logic [NUM_CH-1:0] elig;
  logic              push_ok;
  logic              pop;
  dma_desc_t         head_desc;
  logic [NUM_CH-1:0] arb_gnt;
  logic [CH_LOG-1:0] arb_idx;
  logic              arb_valid;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_empty[c] = (count_q[c] == '0);
      ch_full[c]  = (count_q[c] == (RD_LOG+1)'(RING_DEPTH));
    end
  end

  assign desc_ready = ~ch_full[desc_ch];
  assign push_ok    = desc_push & desc_ready;
  assign elig       = ch_enable & ~ch_empty;
  assign head_desc  = ring_q[gnt_q][head_q[gnt_q]];
  assign busy       = (state_q != IDLE);
  assign active_ch  = busy ? gnt_q : '0;

  boreal_dma_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .req     (elig),
    .last    (gnt_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .valid   (arb_valid)
  );

  // Ring pointer update; a push and a pop on the same channel cancel in count.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      logic push_c, pop_c;
      push_c     = push_ok && (desc_ch == CH_LOG'(c));
      pop_c      = pop && gnt_oh_q[c];
      head_d[c]  = pop_c  ? head_q[c] + RD_LOG'(1) : head_q[c];
      tail_d[c]  = push_c ? tail_q[c] + RD_LOG'(1) : tail_q[c];
      count_d[c] = count_q[c];
      if (push_c && !pop_c)      count_d[c] = count_q[c] + (RD_LOG+1)'(1);
      else if (!push_c && pop_c) count_d[c] = count_q[c] - (RD_LOG+1)'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_oh_d  = gnt_oh_q;
    desc_d    = desc_q;
    i_d       = i_q;
    rdata_d   = rdata_q;
    pop       = 1'b0;
    mem_sel   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = '0;
    unique case (state_q)
      IDLE: if (|elig) state_d = ARB;
      ARB: begin
        if (arb_valid) begin
          gnt_d    = arb_idx;
          gnt_oh_d = arb_gnt;
          state_d  = FETCH;
        end else begin
          state_d  = IDLE;
        end
      end
      FETCH: begin
        desc_d  = head_desc;
        i_d     = '0;
        pop     = 1'b1;
        state_d = (head_desc.len == '0) ? NEXT : READ;
      end
      READ, WAIT_R: begin
        mem_sel  = 1'b1;
        mem_addr = desc_q.src + ADDR_W'(i_q);
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = WRITE;
        end else begin
          state_d = WAIT_R;
        end
      end
      WRITE, WAIT_W: begin
        mem_sel   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = desc_q.dst + ADDR_W'(i_q);
        mem_wdata = rdata_q;
        if (mem_ack) begin
          i_d     = i_q + LEN_W'(1);
          state_d = (i_d == desc_q.len) ? NEXT : READ;
        end else begin
          state_d = WAIT_W;
        end
      end
      NEXT: begin
        done    = gnt_oh_q;
        state_d = (|elig) ? ARB : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignment so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      // Start just below channel 0 so the first grant after reset is channel 0.
      gnt_q    <= CH_LOG'(NUM_CH - 1);
      gnt_oh_q <= '0;
      desc_q   <= '0;
      i_q      <= '0;
      rdata_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        head_q[c]  <= '0;
        tail_q[c]  <= '0;
        count_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_oh_q <= gnt_oh_d;
      desc_q   <= desc_d;
      i_q      <= i_d;
      rdata_q  <= rdata_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  // NOTE: ring storage has no reset; clearing head/tail/count makes stale
  // entries unreachable, so resetting the array itself buys nothing.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      ring_q[desc_ch][tail_q[desc_ch]] <= '{src: desc_src, dst: desc_dst, len: desc_len};
    end
  end

endmodule

// File: tb/tb_boreal_dma_mc_ring.sv
module tb_boreal_dma_mc_ring;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        desc_push = 1'b0;
  logic [1:0]  desc_ch = '0;
  logic [9:0]  desc_src = '0;
  logic [9:0]  desc_dst = '0;
  logic [7:0]  desc_len = '0;
  logic        desc_ready;
  logic [3:0]  ch_enable = '0;
  logic        mem_sel, mem_wr;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic [1:0]  active_ch;
  logic [3:0]  done, ch_empty;

  bit ack_always = 1'b1;
  int ack_delay  = 0;
  int wait_cnt   = 0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] data;
    int          ch;
  } acc_t;

  acc_t acc_q[$];
  int   done_q[$];
  acc_t exp_a;

  bit          prev_pend = 1'b0;
  logic [9:0]  prev_addr;
  logic        prev_wr;
  logic [31:0] prev_wdata;

  boreal_dma_mc_ring dut (
    .clk(clk), .rst(rst),
    .desc_push(desc_push), .desc_ch(desc_ch), .desc_src(desc_src),
    .desc_dst(desc_dst), .desc_len(desc_len), .desc_ready(desc_ready),
    .ch_enable(ch_enable),
    .mem_sel(mem_sel), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .active_ch(active_ch), .done(done), .ch_empty(ch_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [9:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  // Memory model: read data is a fixed function of the address.
  assign mem_rdata = rd_fn(mem_addr);
  assign mem_ack   = ack_always || (mem_sel && (wait_cnt == ack_delay));

  always @(posedge clk) begin
    if (mem_sel && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: enqueue the accesses and done pulse a descriptor must produce.
  task automatic expect_desc(input int ch, input logic [9:0] src, input logic [9:0] dst,
                             input int len);
    for (int i = 0; i < len; i++) begin
      logic [9:0] s, d;
      s = src + 10'(i);
      d = dst + 10'(i);
      acc_q.push_back('{wr: 1'b0, addr: s, data: 32'd0,  ch: ch});
      acc_q.push_back('{wr: 1'b1, addr: d, data: rd_fn(s), ch: ch});
    end
    done_q.push_back(ch);
  endtask

  task automatic push(input int ch, input logic [9:0] src, input logic [9:0] dst,
                      input int len);
    desc_push = 1'b1;
    desc_ch   = 2'(ch);
    desc_src  = src;
    desc_dst  = dst;
    desc_len  = 8'(len);
    @(posedge clk);
    #1 desc_push = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    acc_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    repeat (3) @(negedge clk);
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", busy, 1'b0);
    check("acc_left", acc_q.size(), 0);
    check("done_left", done_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: hold stability, access scoreboard and done pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_pend <= 1'b0;
    end else begin
      if (prev_pend) begin
        check("hold_sel", mem_sel, 1'b1);
        check("hold_addr", mem_addr, prev_addr);
        check("hold_wr", mem_wr, prev_wr);
        check("hold_wdata", mem_wdata, prev_wdata);
      end
      if (mem_sel && mem_ack) begin
        if (acc_q.size() == 0) begin
          check("acc_extra", 1, 0);
        end else begin
          exp_a = acc_q.pop_front();
          check("acc_wr", mem_wr, exp_a.wr);
          check("acc_addr", mem_addr, exp_a.addr);
          check("acc_ch", active_ch, exp_a.ch);
          if (exp_a.wr) check("acc_data", mem_wdata, exp_a.data);
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (done[c]) begin
          if (done_q.size() == 0) check("done_extra", c, 99);
          else                    check("done_ch", c, done_q.pop_front());
        end
      end
      prev_pend  <= mem_sel && !mem_ack;
      prev_addr  <= mem_addr;
      prev_wr    <= mem_wr;
      prev_wdata <= mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_sel", mem_sel, 1'b0);
    check("rst_wr", mem_wr, 1'b0);
    check("rst_addr", mem_addr, 10'd0);
    check("rst_done", done, 4'd0);
    check("rst_empty", ch_empty, 4'hF);
    check("rst_active", active_ch, 2'd0);
    check("rst_ready", desc_ready, 1'b1);
    do_reset();

    // 1: single descriptor, ack tied high
    ch_enable = 4'hF;
    expect_desc(0, 10'h010, 10'h200, 3);
    push(0, 10'h010, 10'h200, 3);
    check("t1_not_empty", ch_empty[0], 1'b0);
    wait_idle(100);
    check("t1_empty", ch_empty, 4'hF);

    // 2: round-robin service order
    do_reset();
    ch_enable = 4'h0;
    for (int c = 0; c < 4; c++) begin
      expect_desc(c, 10'h100 + 10'(16*c), 10'h300 + 10'(16*c), 2);
      push(c, 10'h100 + 10'(16*c), 10'h300 + 10'(16*c), 2);
    end
    check("t2_queued", ch_empty, 4'h0);
    ch_enable = 4'hF;
    wait_idle(200);
    ch_enable = 4'h0;
    // Last grant is 3: ch1 is served before ch3 despite push order.
    expect_desc(1, 10'h050, 10'h060, 2);
    expect_desc(3, 10'h070, 10'h080, 2);
    push(3, 10'h070, 10'h080, 2);
    push(1, 10'h050, 10'h060, 2);
    ch_enable = 4'hF;
    wait_idle(200);

    // 3: fill ring, overflow push dropped
    do_reset();
    ch_enable = 4'h0;
    for (int k = 0; k < 16; k++) begin
      expect_desc(2, 10'h040 + 10'(k), 10'h080 + 10'(k), 1);
      push(2, 10'h040 + 10'(k), 10'h080 + 10'(k), 1);
    end
    desc_ch = 2'd2;
    #1 check("t3_full_ready", desc_ready, 1'b0);
    desc_ch = 2'd0;
    #1 check("t3_other_ready", desc_ready, 1'b1);
    push(2, 10'h3A0, 10'h3B0, 1);
    check("t3_not_empty", ch_empty[2], 1'b0);
    ch_enable = 4'h4;
    wait_idle(300);
    check("t3_empty", ch_empty, 4'hF);

    // 4: zero-length descriptor timing, then address wrap
    ch_enable = 4'hF;
    expect_desc(2, 10'h000, 10'h000, 0);
    push(2, 10'h000, 10'h000, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_done_early", done, 4'h0);
      check("t4_no_sel", mem_sel, 1'b0);
    end
    @(negedge clk);
    check("t4_done_at3", done, 4'h4);
    check("t4_no_sel", mem_sel, 1'b0);
    wait_idle(50);
    expect_desc(1, 10'h3FF, 10'h100, 2);
    push(1, 10'h3FF, 10'h100, 2);
    wait_idle(100);

    // 5: delayed ack, then reset in the middle of a write wait
    ack_always = 1'b0;
    ack_delay  = 4;
    expect_desc(0, 10'h120, 10'h140, 2);
    push(0, 10'h120, 10'h140, 2);
    wait_idle(200);
    ch_enable = 4'h1;
    expect_desc(0, 10'h1A0, 10'h1C0, 3);
    push(0, 10'h1A0, 10'h1C0, 3);
    push(1, 10'h1E0, 10'h1F0, 1);
    begin
      int k;
      k = 0;
      while (!(mem_sel && mem_wr && !mem_ack) && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    check("t5_in_wait_w", mem_sel && mem_wr && !mem_ack, 1'b1);
    rst = 1'b1;
    acc_q.delete();
    done_q.delete();
    #1;
    check("t5_rst_sel", mem_sel, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_empty", ch_empty, 4'hF);
    check("t5_rst_done", done, 4'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ch_enable  = 4'hF;
    ack_always = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_stay_idle", busy, 1'b0);
    check("t5_post_empty", ch_empty, 4'hF);
    @(posedge clk);
    #1;

    // 6: push into ch1 in the same cycle FETCH pops ch1 (count 5)
    ch_enable = 4'h0;
    for (int k = 0; k < 5; k++) begin
      expect_desc(1, 10'h020 + 10'(k), 10'h2A0 + 10'(k), 1);
      push(1, 10'h020 + 10'(k), 10'h2A0 + 10'(k), 1);
    end
    expect_desc(1, 10'h02F, 10'h2AF, 1);
    ch_enable = 4'h2;
    repeat (2) @(posedge clk);
    #1;
    desc_ch = 2'd1;
    #1 check("t6_ready", desc_ready, 1'b1);
    push(1, 10'h02F, 10'h2AF, 1);
    wait_idle(300);
    check("t6_empty", ch_empty, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
